// File: rtl/mem_pkg.sv
// Shared data-memory definitions: AddrMode encoding, idle mode, store/alignment helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: addr_mode_t (memory AddrMode pins), MODE_IDLE, is_store(), is_aligned().
package mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b011,
    LHU = 3'b100,
    SB  = 3'b101,
    SH  = 3'b110,
    SW  = 3'b111
  } addr_mode_t;

  // A load mode so an idle memory can never be written.
  localparam addr_mode_t MODE_IDLE = LW;

  function automatic logic is_store(input addr_mode_t mode);
    return (mode == SB) || (mode == SH) || (mode == SW);
  endfunction

  // Halfwords need an even address, words a multiple of four; bytes are always aligned.
  function automatic logic is_aligned(input addr_mode_t mode, input logic [1:0] addr_lo);
    logic ok;
    case (mode)
      LH, LHU, SH: ok = (addr_lo[0] == 1'b0);
      LW, SW:      ok = (addr_lo == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the port not granted most recently wins.
// Latency: combinational grant in the request cycle; history updated at the next edge.
// Backpressure: a losing request simply stays ungranted until it wins or is withdrawn.
// Ports: clk, rst (sync, active-high), req[1:0] in; gnt[1:0] one-hot out (0 while rst).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Index of the most recently granted port; resets to 1 so port 0 wins the first tie.
  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) begin
        gnt = last_gnt_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end

    last_gnt_d = last_gnt_q;
    if (gnt[0]) begin
      last_gnt_d = 1'b0;
    end else if (gnt[1]) begin
      last_gnt_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one byte-addressed data memory between the LSU (port 0) and a loader/DMA (port 1).
// Latency: grant and memory pins combinational in cycle N; response registered, valid in N+1.
// Backpressure: a requester holds its request until gnt; at most one access per cycle.
// Ports: req_i/modeX_i/addrX_i/wdataX_i requests, gnt_o grant, rvalid_o/rdata_o/err_o response,
//        mem_mode_o/mem_addr_o/mem_wdata_o/mem_rdata_i to the memory AddrMode/A/WD/RD pins.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ADDR_REAL_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_i,
  input  logic [2:0]            mode0_i,
  input  logic [2:0]            mode1_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic [2:0]            mem_mode_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  logic [1:0]            gnt;
  logic [2:0]            sel_mode;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  in_range;
  logic                  legal;
  logic                  use_mem;

  logic [1:0]            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic                  err_q,    err_d;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_i),
    .gnt (gnt)
  );

  assign gnt_o = gnt;

  always_comb begin
    sel_mode  = gnt[1] ? mode1_i  : mode0_i;
    sel_addr  = gnt[1] ? addr1_i  : addr0_i;
    sel_wdata = gnt[1] ? wdata1_i : wdata0_i;

    // Every bit above the implemented memory range must be zero.
    in_range = ((sel_addr >> ADDR_REAL_WIDTH) == '0);
    legal    = in_range && is_aligned(addr_mode_t'(sel_mode), sel_addr[1:0]);
    use_mem  = (gnt != 2'b00) && legal;

    // Rejected or absent accesses park the memory on a harmless load of address 0.
    mem_mode_o  = use_mem ? sel_mode  : MODE_IDLE;
    mem_addr_o  = use_mem ? sel_addr  : '0;
    mem_wdata_o = use_mem ? sel_wdata : '0;

    // rdata/err only change on a grant; they are qualified by rvalid.
    rvalid_d = gnt;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (gnt != 2'b00) begin
      err_d   = !legal;
      rdata_d = (legal && !is_store(addr_mode_t'(sel_mode))) ? mem_rdata_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a small byte-addressed memory model on the pins.
// Latency: each vector drives one cycle; grant/pins checked mid-cycle, response after the edge.
// Backpressure: n/a (directed vectors).
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [2:0]  mode0, mode1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [2:0]  mem_mode;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(
    .DATA_WIDTH      (32),
    .ADDR_WIDTH      (32),
    .ADDR_REAL_WIDTH (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .mode0_i     (mode0),
    .mode1_i     (mode1),
    .addr0_i     (addr0),
    .addr1_i     (addr1),
    .wdata0_i    (wdata0),
    .wdata1_i    (wdata1),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .err_o       (err),
    .mem_mode_o  (mem_mode),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model (4 KiB, little-endian) ----------------
  logic [7:0]  mem_b [0:4095];
  logic        tb_init;
  logic [11:0] ma;
  logic [7:0]  b0, b1, b2, b3;

  always_comb begin
    ma = mem_addr[11:0];
    b0 = mem_b[ma];
    b1 = mem_b[ma + 12'd1];
    b2 = mem_b[ma + 12'd2];
    b3 = mem_b[ma + 12'd3];
    case (mem_mode)
      3'b000:  mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b010:  mem_rdata = {b3, b2, b1, b0};
      3'b011:  mem_rdata = {24'd0, b0};
      3'b100:  mem_rdata = {16'd0, b1, b0};
      default: mem_rdata = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 4096; i++) mem_b[i] <= 8'd0;
    end else begin
      case (mem_mode)
        3'b101: mem_b[ma] <= mem_wdata[7:0];
        3'b110: begin
          mem_b[ma]         <= mem_wdata[7:0];
          mem_b[ma + 12'd1] <= mem_wdata[15:8];
        end
        3'b111: begin
          mem_b[ma]         <= mem_wdata[7:0];
          mem_b[ma + 12'd1] <= mem_wdata[15:8];
          mem_b[ma + 12'd2] <= mem_wdata[23:16];
          mem_b[ma + 12'd3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [2:0]  m0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [2:0]  m1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [1:0]  e_gnt;
    logic [2:0]  e_mode;
    logic [31:0] e_addr;
    logic [1:0]  e_rvalid;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] rq,
                              input logic [2:0] m0, input logic [31:0] a0, input logic [31:0] d0,
                              input logic [2:0] m1, input logic [31:0] a1, input logic [31:0] d1,
                              input logic [1:0] eg, input logic [2:0] em, input logic [31:0] ea,
                              input logic [1:0] ev, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.rst = r;   v.req = rq;
    v.m0 = m0;   v.a0 = a0;  v.d0 = d0;
    v.m1 = m1;   v.a1 = a1;  v.d1 = d1;
    v.e_gnt = eg; v.e_mode = em; v.e_addr = ea;
    v.e_rvalid = ev; v.e_rdata = ed; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle: check grant/pins mid-cycle, then the response just after the edge.
  task automatic run_vec(input vec_t v, input string tag);
    rst = v.rst; req = v.req;
    mode0 = v.m0; addr0 = v.a0; wdata0 = v.d0;
    mode1 = v.m1; addr1 = v.a1; wdata1 = v.d1;
    #2;
    chk({tag, " gnt"},      32'(gnt),      32'(v.e_gnt));
    chk({tag, " mem_mode"}, 32'(mem_mode), 32'(v.e_mode));
    chk({tag, " mem_addr"}, mem_addr,      v.e_addr);
    @(posedge clk);
    #1;
    chk({tag, " rvalid"}, 32'(rvalid), 32'(v.e_rvalid));
    if (v.e_rvalid != 2'b00) begin
      chk({tag, " rdata"}, rdata,      v.e_rdata);
      chk({tag, " err"},   32'(err),   32'(v.e_err));
    end
  endtask

  localparam logic [2:0] M_LB = 3'b000, M_LBU = 3'b011, M_LW = 3'b010;
  localparam logic [2:0] M_SB = 3'b101, M_SH = 3'b110, M_SW = 3'b111;

  vec_t vq[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tb_init = 1'b1; req = 2'b00;
    mode0 = M_LW; mode1 = M_LW;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    tb_init = 1'b0;

    // Reset: both requesting, nothing granted, idle pins.
    run_vec(mk(1, 2'b11, M_LW, 32'h100, 0, M_LW, 32'h200, 0, 2'b00, M_LW, 0, 2'b00, 0, 0), "reset");
    chk("reset rdata", rdata, 32'd0);
    chk("reset err",   32'(err), 32'd0);

    // Port 0 store then load-back, then an idle cycle.
    vq.push_back(mk(0, 2'b01, M_SW, 32'h100, 32'h12345678, M_LW, 0, 0, 2'b01, M_SW, 32'h100, 2'b01, 0, 0));
    vq.push_back(mk(0, 2'b01, M_LW, 32'h100, 0, M_LW, 0, 0, 2'b01, M_LW, 32'h100, 2'b01, 32'h12345678, 0));
    vq.push_back(mk(0, 2'b00, M_LW, 32'h100, 0, M_LW, 0, 0, 2'b00, M_LW, 0, 2'b00, 0, 0));
    // Port 0 illegal accesses: misaligned LW, misaligned SH, out of range; then 0x200 untouched.
    vq.push_back(mk(0, 2'b01, M_LW, 32'h102, 0, M_LW, 0, 0, 2'b01, M_LW, 0, 2'b01, 0, 1));
    vq.push_back(mk(0, 2'b01, M_SH, 32'h201, 32'hFFFF, M_LW, 0, 0, 2'b01, M_LW, 0, 2'b01, 0, 1));
    vq.push_back(mk(0, 2'b01, M_LW, 32'h00100000, 0, M_LW, 0, 0, 2'b01, M_LW, 0, 2'b01, 0, 1));
    vq.push_back(mk(0, 2'b01, M_LW, 32'h200, 0, M_LW, 0, 0, 2'b01, M_LW, 32'h200, 2'b01, 0, 0));
    // Port 1 byte store, then zero- and sign-extended byte loads.
    vq.push_back(mk(0, 2'b10, M_LW, 0, 0, M_SB, 32'h203, 32'hAB, 2'b10, M_SB, 32'h203, 2'b10, 0, 0));
    vq.push_back(mk(0, 2'b10, M_LW, 0, 0, M_LBU, 32'h203, 0, 2'b10, M_LBU, 32'h203, 2'b10, 32'h000000AB, 0));
    vq.push_back(mk(0, 2'b10, M_LW, 0, 0, M_LB, 32'h203, 0, 2'b10, M_LB, 32'h203, 2'b10, 32'hFFFFFFAB, 0));
    // Both ports requesting continuously: strict alternation starting with port 0.
    for (int i = 0; i < 3; i++) begin
      vq.push_back(mk(0, 2'b11, M_LW, 32'h100, 0, M_LW, 32'h200, 0, 2'b01, M_LW, 32'h100, 2'b01, 32'h12345678, 0));
      vq.push_back(mk(0, 2'b11, M_LW, 32'h100, 0, M_LW, 32'h200, 0, 2'b10, M_LW, 32'h200, 2'b10, 32'hAB000000, 0));
    end

    for (int i = 0; i < vq.size(); i++) begin
      run_vec(vq[i], $sformatf("vec%0d", i));
    end

    // Reset in the cycle after a granted load discards the response; port 0 wins the next tie.
    run_vec(mk(0, 2'b01, M_LW, 32'h100, 0, M_LW, 0, 0, 2'b01, M_LW, 32'h100, 2'b01, 32'h12345678, 0), "rst_a");
    run_vec(mk(1, 2'b11, M_LW, 32'h100, 0, M_LW, 32'h200, 0, 2'b00, M_LW, 0, 2'b00, 0, 0), "rst_b");
    run_vec(mk(0, 2'b11, M_LW, 32'h100, 0, M_LW, 32'h200, 0, 2'b01, M_LW, 32'h100, 2'b01, 32'h12345678, 0), "rst_c");

    // Port 0 withdraws a store while port 1 wins; the store must never reach memory.
    run_vec(mk(0, 2'b11, M_SW, 32'h300, 32'hDEADBEEF, M_LW, 32'h300, 0, 2'b10, M_LW, 32'h300, 2'b10, 0, 0), "wd_a");
    run_vec(mk(0, 2'b00, M_SW, 32'h300, 32'hDEADBEEF, M_LW, 32'h300, 0, 2'b00, M_LW, 0, 2'b00, 0, 0), "wd_b");
    run_vec(mk(0, 2'b10, M_LW, 0, 0, M_LW, 32'h300, 0, 2'b10, M_LW, 32'h300, 2'b10, 0, 0), "wd_c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single byte-addressed data memory between the CPU load/store unit (port 0) and a secondary master (port 1: loader/DMA). Sits between both requesters and the data memory's `AddrMode`/`A`/`WD`/`RD` pins.
- Grants at most one access per cycle, round-robin.
- Registers load data into a one-cycle-latency response.
- Rejects misaligned or out-of-range accesses before they reach memory.
- Keeps the memory in a non-writing mode whenever no access is granted.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bus width
- `ADDR_WIDTH`, 32, requester address width
- `ADDR_REAL_WIDTH`, 20, implemented memory address bits; higher address bits must be zero

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_i[1:0]`  in  2  per-port request
- `mode0_i`, `mode1_i`  in  3 each  access type, memory AddrMode encoding
- `addr0_i`, `addr1_i`  in  ADDR_WIDTH each  byte address
- `wdata0_i`, `wdata1_i`  in  DATA_WIDTH each  store data
- `gnt_o[1:0]`  out  2  combinational one-hot grant, same cycle as request
- `rvalid_o[1:0]`  out  2  response valid, one cycle after grant
- `rdata_o`  out  DATA_WIDTH  registered load data, shared by both ports
- `err_o`  out  1  qualifies `rvalid_o`: access rejected
- `mem_mode_o`  out  3  to memory AddrMode
- `mem_addr_o`  out  ADDR_WIDTH  to memory A
- `mem_wdata_o`  out  DATA_WIDTH  to memory WD
- `mem_rdata_i`  in  DATA_WIDTH  from memory RD (combinational)

## Operation
- Mode encoding:
  - 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU: loads
  - 101 SB, 110 SH, 111 SW: stores
- Arbitration:
  - One request pending: that port is granted.
  - Both pending: the port not granted most recently wins.
  - `last_gnt` is updated only on a grant; reset value 1, so port 0 wins the first tie.
- A requester holds `req`, mode, addr and wdata stable until it sees `gnt`. Deasserting `req` before `gnt` is legal; the request is simply withdrawn.
- Legality check on the granted request, combinational:
  - LH/LHU/SH require `addr[0]==0`.
  - LW/SW require `addr[1:0]==0`.
  - `addr[ADDR_WIDTH-1:ADDR_REAL_WIDTH]` must be zero.
- Granted and legal: memory pins take the request's mode/addr/wdata.
- Granted and illegal: the grant is still given and a response is still produced, but memory pins take the idle values and `err_o=1` with the response.
- Idle (no grant, illegal, or `rst`): `mem_mode_o=3'b010` (LW, never a store), `mem_addr_o=0`, `mem_wdata_o=0`.
- Response register, updated on each grant:
  - `rvalid_o` is one-hot, same port as the grant.
  - `rdata_o` = `mem_rdata_i` for legal loads; 0 for stores and errors.
  - `err_o` per the legality check.
- No grant in a cycle: `rvalid_o` drops to 0 next cycle. `rdata_o` and `err_o` hold their values; they are only meaningful while `rvalid_o` is set.

## Timing
- Reset values: `gnt_o=0`, `rvalid_o=0`, `rdata_o=0`, `err_o=0`, `last_gnt=1`, memory pins at idle values.
- `gnt_o` is forced to 0 while `rst=1`.
- Cycle N: `gnt` asserted. A store commits to memory at the rising edge ending N; load data is captured at the same edge.
- Cycle N+1: `rvalid`/`rdata`/`err` are valid for exactly one cycle.
- Throughput: one access per cycle, back-to-back on the same port or alternating.
  - Both ports continuously requesting: grants alternate 0,1,0,1.
- Load after store to the same address in consecutive cycles returns the new data, because the memory write lands before the next cycle's combinational read.
- Reset asserted in cycle N+1 with a response pending: the response is discarded (`rvalid_o=0` from N+2). A store already committed at the end of N is not undone.

## Structure
- `mem_pkg` holds:
  - `addr_mode_t` enum (LB..SW, values as above)
  - `MODE_IDLE=LW`
  - `is_store()` and `is_aligned()` functions
- `mem_pkg` is shared with the memory and LSU.
- Sub-module `rr_arb2`: 2-input round-robin arbiter.
  - Inputs `clk`, `rst`, `req[1:0]`.
  - Output `gnt[1:0]`.
  - Owns `last_gnt`.
- `dmem_arbiter` holds the mux, legality check and response register.

## Test plan
- Reset, then port 0 issues SW 0x12345678 to 0x100, then LW 0x100 → `gnt0` in each cycle; second response has `rdata_o=0x12345678`, `err_o=0`; memory mode is 010 in idle cycles.
- Both ports request LW continuously for 6 cycles → `gnt` sequence 01,10,01,10,01,10; `rvalid` follows one cycle later.
- Port 1 issues SB 0xAB to 0x203, then LBU 0x203 and LB 0x203 → `rdata_o` is 0x000000AB, then 0xFFFFFFAB.
- Port 0 LW at 0x102, then SH at 0x201, then LW at 0x00100000 → each gets `rvalid0` with `err_o=1` and `rdata_o=0`; memory mode stays 010; bytes 0x200-0x203 are unchanged.
- `rst` asserted the cycle after a granted LW → `rvalid_o` is 0 in the following cycle; after reset release with both ports requesting, port 0 wins.
- Port 0 raises `req`, drops it before a grant while port 1 is winning → no grant or response for port 0; no stray memory write.
